// File: rtl/aes_round_key_mem_pkg.sv
// Constants, state type and helpers for the AES key schedule: round counts,
// key-length encoding, Rcon handling and the forward S-box table.
package aes_round_key_mem_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    // Chosen so that the first gm2() step yields 8'h01.
    localparam logic [7:0] RCON_INIT = 8'h8d;

    typedef enum logic {
        IDLE,
        GEN
    } key_state_e;

    function automatic logic [7:0] gm2(input logic [7:0] op);
        return {op[6:0], 1'b0} ^ (op[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_round_key_mem_sbox.sv
// Forward AES S-box applied to all four bytes of a 32-bit word (SubWord).
module aes_sbox
    import aes_round_key_mem_pkg::*;
(
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    assign new_sboxw = {SBOX[sboxw[31:24]], SBOX[sboxw[23:16]],
                        SBOX[sboxw[15:8]],  SBOX[sboxw[7:0]]};

endmodule

// File: rtl/aes_round_key_mem.sv
// AES-128/256 key expansion: generates one round key per cycle after init and
// stores all round keys for combinational lookup by round index.
module aes_round_key_mem
    import aes_round_key_mem_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic         keylen,
    input  logic         init,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);

    logic [127:0] key_mem [0:14];
    logic [127:0] prev_key0_reg;   // key two rounds back (AES-256 chaining source)
    logic [127:0] prev_key1_reg;   // last generated key (S-box source)
    logic [3:0]   ctr_reg;
    logic [7:0]   rcon_reg;
    logic         keylen_reg;
    logic         ready_reg;
    key_state_e   state_reg, state_next;

    logic         start_gen, finish_gen;
    logic [3:0]   final_ctr;
    logic [31:0]  last_w3, sboxw, new_sboxw, t_word;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] base_key, new_key;
    logic [7:0]   rcon_next;
    logic         rot_step, rcon_step, direct_load;

    aes_sbox u_sbox (
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    assign final_ctr = (keylen_reg == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
    assign last_w3   = prev_key1_reg[31:0];

    // AES-256 odd steps use SubWord without RotWord and without Rcon.
    assign rot_step  = (keylen_reg == AES_128_BIT_KEY) || !ctr_reg[0];
    assign rcon_step = (keylen_reg == AES_128_BIT_KEY) ? (ctr_reg != 4'd0)
                                                       : ((ctr_reg >= 4'd2) && !ctr_reg[0]);
    assign sboxw     = rot_step ? {last_w3[23:0], last_w3[31:24]} : last_w3;
    assign rcon_next = gm2(rcon_reg);
    assign t_word    = new_sboxw ^ (rcon_step ? {rcon_next, 24'h0} : 32'h0);

    assign base_key  = (keylen_reg == AES_128_BIT_KEY) ? prev_key1_reg : prev_key0_reg;
    assign w0 = base_key[127:96] ^ t_word;
    assign w1 = base_key[95:64]  ^ w0;
    assign w2 = base_key[63:32]  ^ w1;
    assign w3 = base_key[31:0]   ^ w2;

    // The first one (AES-128) or two (AES-256) round keys are the cipher key itself,
    // which the shift register presents in prev_key0_reg at those steps.
    assign direct_load = (ctr_reg == 4'd0) ||
                         ((keylen_reg == AES_256_BIT_KEY) && (ctr_reg == 4'd1));
    assign new_key     = direct_load ? prev_key0_reg : {w0, w1, w2, w3};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // NOTE: every output of a combinational block gets a default before the case
    // so that no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state_reg;
        start_gen  = 1'b0;
        finish_gen = 1'b0;
        case (state_reg)
            IDLE: begin
                if (init) begin
                    start_gen  = 1'b1;
                    state_next = GEN;
                end
            end
            GEN: begin
                if (ctr_reg == final_ctr) begin
                    finish_gen = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the key array is reset along with the control state so that a reset
    // mid-expansion leaves no partially written keys readable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++) key_mem[i] <= '0;
            prev_key0_reg <= '0;
            prev_key1_reg <= '0;
            ctr_reg       <= 4'd0;
            rcon_reg      <= RCON_INIT;
            keylen_reg    <= AES_128_BIT_KEY;
            ready_reg     <= 1'b1;
        end else if (start_gen) begin
            keylen_reg    <= keylen;
            prev_key0_reg <= key[255:128];
            prev_key1_reg <= key[127:0];
            ctr_reg       <= 4'd0;
            rcon_reg      <= RCON_INIT;
            ready_reg     <= 1'b0;
        end else if (state_reg == GEN) begin
            key_mem[ctr_reg] <= new_key;
            prev_key0_reg    <= prev_key1_reg;
            prev_key1_reg    <= new_key;
            if (rcon_step) rcon_reg <= rcon_next;
            if (finish_gen) ready_reg <= 1'b1;
            else            ctr_reg   <= ctr_reg + 4'd1;
        end
    end

    assign round_key = (round == 4'hf) ? '0 : key_mem[round];
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_round_key_mem.sv
// Scoreboard bench for aes_round_key_mem: stimulus queues expected round keys and
// ready-low durations; a monitor compares them as reads and ready edges occur.
module tb_aes_round_key_mem;

    logic         clk;
    logic         reset_n;
    logic [255:0] key;
    logic         keylen;
    logic         init;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    aes_round_key_mem dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key       (key),
        .keylen    (keylen),
        .init      (init),
        .round     (round),
        .round_key (round_key),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] exp_key;
    } rd_t;

    rd_t  rd_q[$];
    int   lat_q[$];
    logic rd_req;
    int   n_checks;
    int   n_errors;

    localparam logic [255:0] KEY_SEQ   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_FIPS  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic [255:0] k, input logic kl, input bit push_lat);
        @(posedge clk); #1;
        key    = k;
        keylen = kl;
        init   = 1'b1;
        if (push_lat) lat_q.push_back(kl ? 15 : 11);
        @(posedge clk); #1;
        init   = 1'b0;
    endtask

    task automatic wait_ready(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (ready) return;
            @(posedge clk); #1;
        end
        check("wait_ready_timeout", {127'h0, ready}, 128'h1);
    endtask

    task automatic read(input logic [3:0] r, input logic [127:0] exp);
        rd_t e;
        e.rnd     = r;
        e.exp_key = exp;
        round     = r;
        rd_req    = 1'b1;
        rd_q.push_back(e);
        @(posedge clk); #1;
        rd_req    = 1'b0;
    endtask

    // Monitor: compares reads and measures how long ready stays low.
    initial begin
        int   lo_cnt;
        logic prev_ready;
        rd_t  e;
        lo_cnt     = 0;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                if (rd_q.size() == 0) begin
                    check("read_without_expectation", 128'h1, 128'h0);
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("round_key[%0d]", e.rnd), round_key, e.exp_key);
                    check($sformatf("ready_at_read[%0d]", e.rnd), {127'h0, ready}, 128'h1);
                end
            end
            if (!reset_n) begin
                lo_cnt     = 0;
                prev_ready = 1'b1;
            end else begin
                if (!ready) begin
                    lo_cnt++;
                end else if (!prev_ready) begin
                    if (lat_q.size() == 0)
                        check("unexpected_ready_rise", 128'h1, 128'h0);
                    else
                        check("ready_low_cycles", 128'(lo_cnt), 128'(lat_q.pop_front()));
                    lo_cnt = 0;
                end
                prev_ready = ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        init     = 1'b0;
        key      = '0;
        keylen   = 1'b0;
        round    = 4'd0;
        rd_req   = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state: every index reads zero.
        for (int r = 0; r < 16; r++) read(4'(r), 128'h0);

        // AES-128, sequential key.
        start({KEY_SEQ[255:128], 128'h0}, 1'b0, 1'b1);
        wait_ready(30);
        read(4'd0,  128'h000102030405060708090a0b0c0d0e0f);
        read(4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // AES-128, FIPS-197 key.
        start(KEY_FIPS, 1'b0, 1'b1);
        wait_ready(30);
        read(4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
        read(4'd2,  128'hf2c295f27a96b9435935807a7359f67f);
        read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-256, sequential key.
        start(KEY_SEQ, 1'b1, 1'b1);
        wait_ready(30);
        read(4'd0,  128'h000102030405060708090a0b0c0d0e0f);
        read(4'd1,  128'h101112131415161718191a1b1c1d1e1f);
        read(4'd2,  128'ha573c29fa176c498a97fce93a572c09c);
        read(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read(4'd15, 128'h0);

        // init re-pulsed mid-expansion with another key and keylen is ignored.
        start(KEY_FIPS, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        key    = KEY_SEQ;
        keylen = 1'b1;
        init   = 1'b1;
        @(posedge clk); #1;
        init   = 1'b0;
        wait_ready(30);
        read(4'd2,  128'hf2c295f27a96b9435935807a7359f67f);
        read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset during an AES-256 expansion clears everything at once.
        start(KEY_SEQ, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        read(4'd0,  128'h0);
        read(4'd1,  128'h0);
        read(4'd14, 128'h0);
        reset_n = 1'b1;

        // Fresh AES-128 expansion after the reset.
        start({KEY_SEQ[255:128], 128'h0}, 1'b0, 1'b1);
        wait_ready(30);
        read(4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        read(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        read(4'd14, 128'h0);

        repeat (3) @(posedge clk);
        check("read_queue_drained",    128'(rd_q.size()),  128'h0);
        check("latency_queue_drained", 128'(lat_q.size()), 128'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
